// File: rtl/tx_pend_sched.sv
// Per-flow TX pending-work tracker and round-robin flow scheduler for the TX engine.
// Optional dequeue statistics are compiled in with `define TX_SCHED_STATS_EN.

package tcp_pkg;
    localparam int MAX_TCP_FLOWS = 16;
    localparam int FLOWID_W      = $clog2(MAX_TCP_FLOWS);

    localparam logic [1:0] SCHED_NOP   = 2'd0;
    localparam logic [1:0] SCHED_SET   = 2'd1;
    localparam logic [1:0] SCHED_CLEAR = 2'd2;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] timestamp;
    } sched_set_clear_struct;

    typedef struct packed {
        logic [FLOWID_W-1:0]   flowid;
        sched_set_clear_struct ack_pend_set_clear;
        sched_set_clear_struct data_pend_set_clear;
        sched_set_clear_struct rt_pend_set_clear;
    } sched_cmd_struct;
endpackage

module tx_pend_sched
    import tcp_pkg::*;
#(
    parameter int NUM_FLOWS = MAX_TCP_FLOWS
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                src0_tx_sched_cmd_val,
    input  sched_cmd_struct     src0_tx_sched_cmd_data,
    output logic                tx_sched_src0_cmd_rdy,

    input  logic                src1_tx_sched_cmd_val,
    input  sched_cmd_struct     src1_tx_sched_cmd_data,
    output logic                tx_sched_src1_cmd_rdy,

    output logic                tx_sched_tx_eng_val,
    output logic [FLOWID_W-1:0] tx_sched_tx_eng_flowid,
    output logic                tx_sched_tx_eng_ack_pend,
    output logic                tx_sched_tx_eng_data_pend,
    output logic                tx_sched_tx_eng_rt_pend,
    input  logic                tx_eng_tx_sched_rdy
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [31:0]         tx_sched_deq_cnt,
    output logic [31:0]         tx_sched_rt_deq_cnt
`endif
);

    localparam logic [0:0] ST_SCAN   = 1'b0;
    localparam logic [0:0] ST_OUTPUT = 1'b1;

    logic [0:0]           state;
    logic [FLOWID_W-1:0]  scan_idx;

    logic [NUM_FLOWS-1:0] ack_pend;
    logic [NUM_FLOWS-1:0] data_pend;
    logic [NUM_FLOWS-1:0] rt_pend;
    logic [NUM_FLOWS-1:0] ack_pend_nxt;
    logic [NUM_FLOWS-1:0] data_pend_nxt;
    logic [NUM_FLOWS-1:0] rt_pend_nxt;

    logic                 cmd_val;
    sched_cmd_struct      cmd;
    logic                 deq_fire;
    logic                 scan_hit;
    logic                 unused_timestamps;

    function automatic logic [FLOWID_W-1:0] idx_inc(input logic [FLOWID_W-1:0] idx);
        if (idx == FLOWID_W'(NUM_FLOWS - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // Flow ids outside the tracked range are dropped rather than aliased.
    function automatic logic [NUM_FLOWS-1:0] apply_cmd(
        input logic [NUM_FLOWS-1:0] vec,
        input logic [1:0]           op,
        input logic [FLOWID_W-1:0]  flowid
    );
        logic [NUM_FLOWS-1:0] res;
        res = vec;
        if (int'(flowid) < NUM_FLOWS) begin
            case (op)
                SCHED_SET:   res[flowid] = 1'b1;
                SCHED_CLEAR: res[flowid] = 1'b0;
                default:     res = vec;
            endcase
        end
        return res;
    endfunction

    // Port 0 has fixed priority; port 1 only sees ready when port 0 is idle.
    assign tx_sched_src0_cmd_rdy = 1'b1;
    assign tx_sched_src1_cmd_rdy = ~src0_tx_sched_cmd_val;

    assign cmd_val = src0_tx_sched_cmd_val | src1_tx_sched_cmd_val;
    assign cmd     = src0_tx_sched_cmd_val ? src0_tx_sched_cmd_data : src1_tx_sched_cmd_data;

    assign unused_timestamps = ^{src0_tx_sched_cmd_data.ack_pend_set_clear.timestamp,
                                 src0_tx_sched_cmd_data.data_pend_set_clear.timestamp,
                                 src0_tx_sched_cmd_data.rt_pend_set_clear.timestamp,
                                 src1_tx_sched_cmd_data.ack_pend_set_clear.timestamp,
                                 src1_tx_sched_cmd_data.data_pend_set_clear.timestamp,
                                 src1_tx_sched_cmd_data.rt_pend_set_clear.timestamp};

    // Valid/ready: the flow and its flags are held from the cycle val rises
    // until the cycle in which val and rdy are both high; that cycle is the transfer.
    assign tx_sched_tx_eng_val = (state == ST_OUTPUT);
    assign deq_fire            = tx_sched_tx_eng_val & tx_eng_tx_sched_rdy;

    assign scan_hit = ack_pend[scan_idx] | data_pend[scan_idx] | rt_pend[scan_idx];

    // Dequeue clears go first so a same-cycle command for the same flow wins.
    always_comb begin
        ack_pend_nxt  = ack_pend;
        data_pend_nxt = data_pend;
        rt_pend_nxt   = rt_pend;
        if (deq_fire) begin
            if (tx_sched_tx_eng_ack_pend)  ack_pend_nxt[tx_sched_tx_eng_flowid]  = 1'b0;
            if (tx_sched_tx_eng_data_pend) data_pend_nxt[tx_sched_tx_eng_flowid] = 1'b0;
            if (tx_sched_tx_eng_rt_pend)   rt_pend_nxt[tx_sched_tx_eng_flowid]   = 1'b0;
        end
        if (cmd_val) begin
            ack_pend_nxt  = apply_cmd(ack_pend_nxt,  cmd.ack_pend_set_clear.cmd,  cmd.flowid);
            data_pend_nxt = apply_cmd(data_pend_nxt, cmd.data_pend_set_clear.cmd, cmd.flowid);
            rt_pend_nxt   = apply_cmd(rt_pend_nxt,   cmd.rt_pend_set_clear.cmd,   cmd.flowid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= ST_SCAN;
            scan_idx                  <= '0;
            ack_pend                  <= '0;
            data_pend                 <= '0;
            rt_pend                   <= '0;
            tx_sched_tx_eng_flowid    <= '0;
            tx_sched_tx_eng_ack_pend  <= 1'b0;
            tx_sched_tx_eng_data_pend <= 1'b0;
            tx_sched_tx_eng_rt_pend   <= 1'b0;
        end else begin
            ack_pend  <= ack_pend_nxt;
            data_pend <= data_pend_nxt;
            rt_pend   <= rt_pend_nxt;
            case (state)
                ST_SCAN: begin
                    if (scan_hit) begin
                        tx_sched_tx_eng_flowid    <= scan_idx;
                        tx_sched_tx_eng_ack_pend  <= ack_pend[scan_idx];
                        tx_sched_tx_eng_data_pend <= data_pend[scan_idx];
                        tx_sched_tx_eng_rt_pend   <= rt_pend[scan_idx];
                        state                     <= ST_OUTPUT;
                    end else begin
                        scan_idx <= idx_inc(scan_idx);
                    end
                end
                ST_OUTPUT: begin
                    // Resuming past the serviced flow keeps the scan fair.
                    if (tx_eng_tx_sched_rdy) begin
                        scan_idx <= idx_inc(scan_idx);
                        state    <= ST_SCAN;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sched_deq_cnt    <= '0;
            tx_sched_rt_deq_cnt <= '0;
        end else if (deq_fire) begin
            tx_sched_deq_cnt <= tx_sched_deq_cnt + 32'd1;
            if (tx_sched_tx_eng_rt_pend) begin
                tx_sched_rt_deq_cnt <= tx_sched_rt_deq_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_pend_sched.sv
// Directed bench for tx_pend_sched: a cycle-exact vector table after reset,
// then hand-written multi-cycle sequences for stalls, re-emission and reset.
module tb_tx_pend_sched;
    import tcp_pkg::*;

    localparam int NF = MAX_TCP_FLOWS;

    logic                clk;
    logic                rst;
    logic                src0_val;
    sched_cmd_struct     src0_data;
    logic                src0_rdy;
    logic                src1_val;
    sched_cmd_struct     src1_data;
    logic                src1_rdy;
    logic                eng_val;
    logic [FLOWID_W-1:0] eng_flowid;
    logic                eng_ack;
    logic                eng_data;
    logic                eng_rt;
    logic                eng_rdy;
`ifdef TX_SCHED_STATS_EN
    logic [31:0]         deq_cnt;
    logic [31:0]         rt_deq_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    tx_pend_sched dut (
        .clk                       (clk),
        .rst                       (rst),
        .src0_tx_sched_cmd_val     (src0_val),
        .src0_tx_sched_cmd_data    (src0_data),
        .tx_sched_src0_cmd_rdy     (src0_rdy),
        .src1_tx_sched_cmd_val     (src1_val),
        .src1_tx_sched_cmd_data    (src1_data),
        .tx_sched_src1_cmd_rdy     (src1_rdy),
        .tx_sched_tx_eng_val       (eng_val),
        .tx_sched_tx_eng_flowid    (eng_flowid),
        .tx_sched_tx_eng_ack_pend  (eng_ack),
        .tx_sched_tx_eng_data_pend (eng_data),
        .tx_sched_tx_eng_rt_pend   (eng_rt),
        .tx_eng_tx_sched_rdy       (eng_rdy)
`ifdef TX_SCHED_STATS_EN
        ,
        .tx_sched_deq_cnt          (deq_cnt),
        .tx_sched_rt_deq_cnt       (rt_deq_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic sched_cmd_struct mk_cmd(input int flow, input logic [1:0] a,
                                               input logic [1:0] d, input logic [1:0] r);
        sched_cmd_struct c;
        c.flowid                        = FLOWID_W'(flow);
        c.ack_pend_set_clear.cmd        = a;
        c.ack_pend_set_clear.timestamp  = $urandom;
        c.data_pend_set_clear.cmd       = d;
        c.data_pend_set_clear.timestamp = $urandom;
        c.rt_pend_set_clear.cmd         = r;
        c.rt_pend_set_clear.timestamp   = $urandom;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        src0_val  = 1'b0;
        src0_data = mk_cmd(0, SCHED_NOP, SCHED_NOP, SCHED_NOP);
        src1_val  = 1'b0;
        src1_data = mk_cmd(0, SCHED_NOP, SCHED_NOP, SCHED_NOP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        eng_rdy = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    // Returns the number of cycles waited; an expired budget counts as a failure.
    task automatic wait_val(input string name, input int budget, output int waited);
        waited = 0;
        #1;
        while (!eng_val && waited < budget) begin
            tick();
            #1;
            waited++;
        end
        check(name, {31'b0, eng_val}, 32'd1);
    endtask

    task automatic count_idle_val(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            #1;
            if (eng_val) seen++;
            tick();
        end
        check(name, seen, 0);
    endtask

    task automatic check_out(input string name, input int flow, input logic [2:0] flags);
        check({name, "_flowid"}, 32'(eng_flowid), flow);
        check({name, "_flags"}, {29'b0, eng_ack, eng_data, eng_rt}, {29'b0, flags});
    endtask

    typedef struct {
        logic            s0_val;
        sched_cmd_struct s0_cmd;
        logic            s1_val;
        sched_cmd_struct s1_cmd;
        logic            rdy;
        logic            exp_s1_rdy;
        logic            exp_val;
        int              exp_flow;
        logic [2:0]      exp_flags;  // {ack, data, rt}
    } vec_t;

    vec_t vecs[16];

    task automatic set_vec(input int i, input logic s0v, input sched_cmd_struct s0c,
                           input logic s1v, input sched_cmd_struct s1c, input logic rdy,
                           input logic es1, input logic ev, input int ef, input logic [2:0] efl);
        vecs[i].s0_val     = s0v;
        vecs[i].s0_cmd     = s0c;
        vecs[i].s1_val     = s1v;
        vecs[i].s1_cmd     = s1c;
        vecs[i].rdy        = rdy;
        vecs[i].exp_s1_rdy = es1;
        vecs[i].exp_val    = ev;
        vecs[i].exp_flow   = ef;
        vecs[i].exp_flags  = efl;
    endtask

    initial begin
        sched_cmd_struct nop_c;
        int waited;
        rst = 1'b1;
        eng_rdy = 1'b0;
        idle_inputs();
        nop_c = mk_cmd(0, SCHED_NOP, SCHED_NOP, SCHED_NOP);

        // Cycle-exact table from reset (scan index 0 before the first edge).
        set_vec(0,  1, mk_cmd(2, SCHED_SET, SCHED_NOP, SCHED_NOP), 1, mk_cmd(3, SCHED_NOP, SCHED_NOP, SCHED_SET), 0, 0, 0, 0, 3'b000);
        set_vec(1,  0, nop_c, 1, mk_cmd(3, SCHED_NOP, SCHED_NOP, SCHED_SET), 0, 1, 0, 0, 3'b000);
        set_vec(2,  0, nop_c, 0, nop_c, 0, 1, 0, 0, 3'b000);
        set_vec(3,  0, nop_c, 0, nop_c, 1, 1, 1, 2, 3'b100);
        set_vec(4,  0, nop_c, 0, nop_c, 1, 1, 0, 0, 3'b000);
        set_vec(5,  0, nop_c, 0, nop_c, 1, 1, 1, 3, 3'b001);
        set_vec(6,  1, mk_cmd(9, SCHED_NOP, SCHED_SET, SCHED_NOP), 0, nop_c, 0, 0, 0, 0, 3'b000);
        set_vec(7,  1, mk_cmd(9, SCHED_NOP, SCHED_CLEAR, SCHED_NOP), 0, nop_c, 0, 0, 0, 0, 3'b000);
        set_vec(8,  0, nop_c, 1, mk_cmd(11, SCHED_NOP, SCHED_CLEAR, SCHED_NOP), 0, 1, 0, 0, 3'b000);
        set_vec(9,  0, nop_c, 1, mk_cmd(11, SCHED_NOP, SCHED_SET, SCHED_NOP), 0, 1, 0, 0, 3'b000);
        for (int i = 10; i < 14; i++) set_vec(i, 0, nop_c, 0, nop_c, 0, 1, 0, 0, 3'b000);
        set_vec(14, 0, nop_c, 0, nop_c, 1, 1, 1, 11, 3'b010);
        set_vec(15, 0, nop_c, 0, nop_c, 1, 1, 0, 0, 3'b000);

        @(negedge clk);
        do_reset();
        #1;
        check("reset_val", {31'b0, eng_val}, 0);
        check_out("reset_out", 0, 3'b000);
        check("reset_src0_rdy", {31'b0, src0_rdy}, 1);
        check("reset_src1_rdy", {31'b0, src1_rdy}, 1);

        for (int i = 0; i < 16; i++) begin
            src0_val  = vecs[i].s0_val;
            src0_data = vecs[i].s0_cmd;
            src1_val  = vecs[i].s1_val;
            src1_data = vecs[i].s1_cmd;
            eng_rdy   = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_src0_rdy", i), {31'b0, src0_rdy}, 1);
            check($sformatf("vec%0d_src1_rdy", i), {31'b0, src1_rdy}, {31'b0, vecs[i].exp_s1_rdy});
            check($sformatf("vec%0d_val", i), {31'b0, eng_val}, {31'b0, vecs[i].exp_val});
            if (vecs[i].exp_val) check_out($sformatf("vec%0d", i), vecs[i].exp_flow, vecs[i].exp_flags);
            tick();
        end
        idle_inputs();

        // Idle after reset: no output, both sources ready.
        do_reset();
        begin
            int bad_rdy;
            bad_rdy = 0;
            for (int i = 0; i < 2 * NF; i++) begin
                #1;
                if (src0_rdy !== 1'b1 || src1_rdy !== 1'b1) bad_rdy++;
                tick();
            end
            check("idle_rdy_low_cycles", bad_rdy, 0);
        end
        count_idle_val("idle_val", 1);

        // Single rt request on port 1.
        do_reset();
        src1_val = 1'b1;
        src1_data = mk_cmd(5, SCHED_NOP, SCHED_NOP, SCHED_SET);
        tick();
        idle_inputs();
        eng_rdy = 1'b1;
        wait_val("rt5_val", 2 * NF, waited);
        check_out("rt5", 5, 3'b001);
        tick();
        count_idle_val("rt5_no_repeat", 2 * NF);

        // Flows 0 and 7 behind a stalled engine, issued with the scan at index 9.
        do_reset();
        repeat (9) tick();
        src0_val = 1'b1;
        src0_data = mk_cmd(0, SCHED_NOP, SCHED_SET, SCHED_NOP);
        tick();
        src0_data = mk_cmd(7, SCHED_NOP, SCHED_SET, SCHED_NOP);
        tick();
        idle_inputs();
        wait_val("stall_first_val", 2 * NF, waited);
        check_out("stall_first", 0, 3'b010);
        begin
            int unstable;
            unstable = 0;
            for (int i = 0; i < 10; i++) begin
                tick();
                #1;
                if (eng_val !== 1'b1 || eng_flowid !== FLOWID_W'(0)) unstable++;
            end
            check("stall_hold_unstable", unstable, 0);
        end
        eng_rdy = 1'b1;
        tick();
        wait_val("stall_second_val", 2 * NF, waited);
        check_out("stall_second", 7, 3'b010);
        tick();
        count_idle_val("stall_no_repeat", 2 * NF);

        // SET on an unlatched field in the handshake cycle survives and is re-emitted next wrap.
        do_reset();
        src0_val = 1'b1;
        src0_data = mk_cmd(4, SCHED_SET, SCHED_NOP, SCHED_NOP);
        tick();
        idle_inputs();
        wait_val("f4_first_val", 2 * NF, waited);
        check_out("f4_first", 4, 3'b100);
        src1_val = 1'b1;
        src1_data = mk_cmd(4, SCHED_NOP, SCHED_NOP, SCHED_SET);
        eng_rdy = 1'b1;
        tick();
        idle_inputs();
        #1;
        check("f4_val_drop", {31'b0, eng_val}, 0);
        wait_val("f4_second_val", 2 * NF, waited);
        check("f4_rewrap_latency", waited, NF);
        check_out("f4_second", 4, 3'b001);
        tick();

        // SET on the latched field in the handshake cycle keeps it pending.
        eng_rdy = 1'b0;
        src0_val = 1'b1;
        src0_data = mk_cmd(6, SCHED_NOP, SCHED_SET, SCHED_NOP);
        tick();
        idle_inputs();
        wait_val("f6_first_val", 2 * NF, waited);
        check_out("f6_first", 6, 3'b010);
        src0_val = 1'b1;
        src0_data = mk_cmd(6, SCHED_NOP, SCHED_SET, SCHED_NOP);
        eng_rdy = 1'b1;
        tick();
        idle_inputs();
        wait_val("f6_second_val", 2 * NF, waited);
        check_out("f6_second", 6, 3'b010);
        tick();

        // rt SET during OUTPUT, then CLEAR in the handshake cycle: nothing left.
        eng_rdy = 1'b0;
        src0_val = 1'b1;
        src0_data = mk_cmd(10, SCHED_NOP, SCHED_SET, SCHED_NOP);
        tick();
        idle_inputs();
        wait_val("f10_val", 2 * NF, waited);
        check_out("f10", 10, 3'b010);
        src0_val = 1'b1;
        src0_data = mk_cmd(10, SCHED_NOP, SCHED_NOP, SCHED_SET);
        tick();
        idle_inputs();
        src1_val = 1'b1;
        src1_data = mk_cmd(10, SCHED_NOP, SCHED_NOP, SCHED_CLEAR);
        eng_rdy = 1'b1;
        tick();
        idle_inputs();
        count_idle_val("f10_clear_wins", 2 * NF);

        // Reset while a flow is presented drops it and all pending state.
        eng_rdy = 1'b0;
        src0_val = 1'b1;
        src0_data = mk_cmd(8, SCHED_SET, SCHED_NOP, SCHED_NOP);
        tick();
        src0_data = mk_cmd(12, SCHED_NOP, SCHED_NOP, SCHED_SET);
        tick();
        idle_inputs();
        wait_val("f8_val", 2 * NF, waited);
        check_out("f8", 8, 3'b100);
        rst = 1'b1;
        tick();
        #1;
        check("midrst_val", {31'b0, eng_val}, 0);
        check_out("midrst_out", 0, 3'b000);
        rst = 1'b0;
        eng_rdy = 1'b1;
        count_idle_val("midrst_state_lost", 2 * NF);

`ifdef TX_SCHED_STATS_EN
        do_reset();
        eng_rdy = 1'b1;
        src0_val = 1'b1;
        src0_data = mk_cmd(1, SCHED_SET, SCHED_NOP, SCHED_NOP);
        tick();
        src0_data = mk_cmd(2, SCHED_NOP, SCHED_NOP, SCHED_SET);
        tick();
        src0_data = mk_cmd(3, SCHED_NOP, SCHED_SET, SCHED_NOP);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            wait_val($sformatf("stats_val%0d", i), 2 * NF, waited);
            tick();
        end
        #1;
        check("stats_deq_cnt", deq_cnt, 3);
        check("stats_rt_deq_cnt", rt_deq_cnt, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("stats_deq_cnt_rst", deq_cnt, 0);
        check("stats_rt_deq_cnt_rst", rt_deq_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
